// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin arbiter sharing the regfile write port among NUM_REQ buffered writers
// Define REGFILE_ARB_STATS_EN to add saturating write / x0-drop / stall counters.
module regfile_wr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      wr_stall,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_wa,
  output logic [DATA_W-1:0]         rf_wd,
  output logic [1:0]                grant_id,
  output logic                      idle
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [15:0]               stat_writes,
  output logic [15:0]               stat_x0_drops,
  output logic [15:0]               stat_stall_cycles
`endif
);

  logic [NUM_REQ-1:0]        buf_valid_q, buf_valid_d;
  logic [NUM_REQ*ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [NUM_REQ*DATA_W-1:0] buf_data_q, buf_data_d;
  logic [1:0]                ptr_q, ptr_d;
  logic                      rf_we_q, rf_we_d;
  logic [ADDR_W-1:0]         rf_wa_q, rf_wa_d;
  logic [DATA_W-1:0]         rf_wd_q, rf_wd_d;
  logic [1:0]                grant_id_q, grant_id_d;

  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] x0_hit;
  logic               grant_any;
  logic [1:0]         grant_idx;

  function automatic logic [1:0] wrap_add(input logic [1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return 2'(s);
  endfunction

  // First non-empty buffer at or after the pointer, wrapping around.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = ptr_q;
    if (!wr_stall) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!grant_any && buf_valid_q[wrap_add(ptr_q, k)]) begin
          grant_any = 1'b1;
          grant_idx = wrap_add(ptr_q, k);
        end
      end
    end
    if (grant_any) grant[grant_idx] = 1'b1;
    ptr_d = grant_any ? wrap_add(grant_idx, 1) : ptr_q;
  end

  assign req_ready = ~buf_valid_q | grant;

  // A granted buffer may be refilled on the same edge; addr-0 writes are swallowed.
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    x0_hit      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) buf_valid_d[i] = 1'b0;
      if (req_valid[i] && req_ready[i]) begin
        if (req_addr[i*ADDR_W +: ADDR_W] == '0) begin
          x0_hit[i] = 1'b1;
        end else begin
          buf_valid_d[i]                = 1'b1;
          buf_addr_d[i*ADDR_W +: ADDR_W] = req_addr[i*ADDR_W +: ADDR_W];
          buf_data_d[i*DATA_W +: DATA_W] = req_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    rf_we_d    = grant_any;
    rf_wa_d    = rf_wa_q;
    rf_wd_d    = rf_wd_q;
    grant_id_d = grant_any ? grant_idx : grant_id_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        rf_wa_d = buf_addr_q[i*ADDR_W +: ADDR_W];
        rf_wd_d = buf_data_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      buf_valid_q <= '0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      ptr_q       <= '0;
      rf_we_q     <= 1'b0;
      rf_wa_q     <= '0;
      rf_wd_q     <= '0;
      grant_id_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      ptr_q       <= ptr_d;
      rf_we_q     <= rf_we_d;
      rf_wa_q     <= rf_wa_d;
      rf_wd_q     <= rf_wd_d;
      grant_id_q  <= grant_id_d;
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;
  assign grant_id = grant_id_q;
  assign idle     = !(|buf_valid_q) && !rf_we_q;

`ifdef REGFILE_ARB_STATS_EN
  logic [15:0] stat_writes_q, stat_x0_drops_q, stat_stall_cycles_q;
  int          x0_cnt;

  function automatic logic [15:0] sat_add(input logic [15:0] v, input int inc);
    int s;
    s = int'(v) + inc;
    return (s > 65535) ? 16'hFFFF : 16'(s);
  endfunction

  always_comb begin
    x0_cnt = 0;
    for (int i = 0; i < NUM_REQ; i++) x0_cnt = x0_cnt + int'(x0_hit[i]);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_writes_q       <= '0;
      stat_x0_drops_q     <= '0;
      stat_stall_cycles_q <= '0;
    end else begin
      stat_writes_q       <= sat_add(stat_writes_q, int'(rf_we_q));
      stat_x0_drops_q     <= sat_add(stat_x0_drops_q, x0_cnt);
      stat_stall_cycles_q <= sat_add(stat_stall_cycles_q, int'(wr_stall && (|buf_valid_q)));
    end
  end

  assign stat_writes       = stat_writes_q;
  assign stat_x0_drops     = stat_x0_drops_q;
  assign stat_stall_cycles = stat_stall_cycles_q;
`endif

endmodule
